// File: rtl/mem_resp_model_pkg.sv
// ============================================================================
// Module : mem_resp_model_pkg
// Brief  : Shared widths, port FSM state encoding and address-width helper
//          for the latency-accurate memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_resp_model_pkg;

    localparam int XLEN        = 32;
    localparam int FETCH_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_port_state_e;

    // Word-index width for a power-of-two storage depth.
    function automatic int mem_addr_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_model_port_ctrl.sv
// ============================================================================
// Module : mem_port_ctrl
// Brief  : Per-port request/response FSM with latency counter, stall and
//          response data register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_ctrl
    import mem_resp_model_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_stall,
    output logic              o_dout_val,
    output logic [DATA_W-1:0] o_dout
);

    localparam int c_CNT_W    = (LAT > 2) ? $clog2(LAT) : 1;
    localparam int c_CNT_INIT = (LAT > 1) ? LAT - 2 : 0;
    // A single-cycle port skips BUSY entirely and answers on the next cycle.
    localparam mem_port_state_e c_ACCEPT_STATE = (LAT > 1) ? BUSY : RESP;

    mem_port_state_e    r_state;
    mem_port_state_e    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0]  r_data;
    logic               w_accept;

    assign o_stall    = (r_state == BUSY);
    assign w_accept   = i_req & ~o_stall;
    assign o_dout_val = (r_state == RESP);
    assign o_dout     = o_dout_val ? r_data : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_state_nxt = c_ACCEPT_STATE;
                    w_cnt_nxt   = c_CNT_W'(c_CNT_INIT);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_data <= i_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_resp_model.sv
// ============================================================================
// Module : mem_resp_model
// Brief  : Unified-storage memory responder serving IMEM fetch pairs and DMEM
//          loads/stores with independent configurable latencies.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_resp_model
    import mem_resp_model_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IMEM_LAT    = 1,
    parameter int DMEM_LAT    = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [XLEN-1:0]              icache_addr,
    input  logic                         icache_re,
    output logic [FETCH_WIDTH*XLEN-1:0]  icache_dout,
    output logic                         icache_dout_val,
    output logic                         icache_stall,
    input  logic [XLEN-1:0]              dcache_addr,
    input  logic                         dcache_re,
    output logic [XLEN-1:0]              dcache_dout,
    output logic                         dcache_dout_val,
    output logic                         dcache_stall,
    input  logic [XLEN-1:0]              dcache_din,
    input  logic [XLEN/8-1:0]            dcache_we
);

    localparam int c_ADDR_W = mem_addr_w(DEPTH_WORDS);
    localparam int c_BYTES  = XLEN / 8;

    logic [XLEN-1:0]             r_mem [DEPTH_WORDS];
    logic [c_ADDR_W-1:0]         w_iaddr;
    logic [c_ADDR_W-1:0]         w_iaddr_hi;
    logic [c_ADDR_W-1:0]         w_daddr;
    logic [FETCH_WIDTH*XLEN-1:0] w_ifetch;
    logic [XLEN-1:0]             w_dword;
    logic                        w_store;
    logic                        w_unused_addr_bits;

    // Byte offset and bits above the storage size alias away.
    assign w_iaddr    = icache_addr[c_ADDR_W+1:2];
    assign w_daddr    = dcache_addr[c_ADDR_W+1:2];
    assign w_iaddr_hi = w_iaddr + c_ADDR_W'(1);
    assign w_unused_addr_bits = ^{icache_addr[XLEN-1:c_ADDR_W+2], icache_addr[1:0],
                                  dcache_addr[XLEN-1:c_ADDR_W+2], dcache_addr[1:0]};

    assign w_ifetch = {r_mem[w_iaddr_hi], r_mem[w_iaddr]};
    assign w_dword  = r_mem[w_daddr];
    assign w_store  = (dcache_we != '0) & ~dcache_stall & ~rst;

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (dcache_we[b]) begin
                    r_mem[w_daddr][8*b +: 8] <= dcache_din[8*b +: 8];
                end
            end
        end
    end

    mem_port_ctrl #(
        .LAT    (IMEM_LAT),
        .DATA_W (FETCH_WIDTH*XLEN)
    ) u_imem_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_req      (icache_re),
        .i_rdata    (w_ifetch),
        .o_stall    (icache_stall),
        .o_dout_val (icache_dout_val),
        .o_dout     (icache_dout)
    );

    mem_port_ctrl #(
        .LAT    (DMEM_LAT),
        .DATA_W (XLEN)
    ) u_dmem_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_req      (dcache_re),
        .i_rdata    (w_dword),
        .o_stall    (dcache_stall),
        .o_dout_val (dcache_dout_val),
        .o_dout     (dcache_dout)
    );

endmodule

`default_nettype wire
